// File: rtl/root_uplink_collector_if.sv
// Uplink bundle between the leaf uplinks / root controller and the collector.
// master: the collector side (drives ready back to leaves and the merged stream).
// slave:  the environment side (leaves drive payloads, controller drives out_ready).
interface root_uplink_collector_if #(
    parameter int NUM_LEAVES = 4,
    parameter int ID_W       = 2
);
    logic [64*NUM_LEAVES-1:0] up_rx_data;
    logic [NUM_LEAVES-1:0]    up_rx_valid;
    logic [NUM_LEAVES-1:0]    up_rx_ready;
    logic [63:0]              out_data;
    logic [ID_W-1:0]          out_src_id;
    logic                     out_valid;
    logic                     out_ready;
    logic                     all_done;

    modport master (
        input  up_rx_data, up_rx_valid, out_ready,
        output up_rx_ready, out_data, out_src_id, out_valid, all_done
    );

    modport slave (
        output up_rx_data, up_rx_valid, out_ready,
        input  up_rx_ready, out_data, out_src_id, out_valid, all_done
    );
endinterface

// File: rtl/root_uplink_collector.sv
// root_uplink_collector: terminates NUM_LEAVES leaf uplinks, each into a 2-entry
// FIFO, and merges them round-robin into one registered 64-bit stream tagged with
// the source leaf index.
// Optional feature macro: UPLINK_BARRIER_EN (per-round completion barrier, all_done).
module root_uplink_collector #(
    parameter int         NUM_LEAVES  = 4,
    parameter int         ID_W        = 2,
    parameter logic [7:0] DONE_OPCODE = 8'hFF
) (
    input logic                     clk,
    input logic                     reset,
    root_uplink_collector_if.master bus
);
    logic [NUM_LEAVES-1:0][63:0] slot0_q, slot0_d;
    logic [NUM_LEAVES-1:0][63:0] slot1_q, slot1_d;
    logic [NUM_LEAVES-1:0][1:0]  cnt_q, cnt_d;
    logic [NUM_LEAVES-1:0]       ready_q, ready_d;
    logic [ID_W-1:0]             rr_q, rr_d;
    logic [63:0]                 out_data_q, out_data_d;
    logic [ID_W-1:0]             out_src_q, out_src_d;
    logic                        out_valid_q, out_valid_d;

    logic [NUM_LEAVES-1:0]       req;
    logic [NUM_LEAVES-1:0]       push;
    logic [NUM_LEAVES-1:0]       pop;
    logic                        out_load;
    logic                        grant_vld;
    logic [ID_W-1:0]             grant;
    int                          scan_idx;
    int                          next_rr;

    // The output register can take a new word when empty or being drained this cycle.
    assign out_load = !out_valid_q || bus.out_ready;

    // Lane requests come from registered counts, so a word pushed this cycle waits a cycle.
    always_comb begin
        req  = '0;
        push = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            req[i]  = (cnt_q[i] != 2'd0);
            push[i] = bus.up_rx_valid[i] && ready_q[i];
        end
    end

    // Round-robin search: first requesting lane at or after rr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_LEAVES) begin
                scan_idx = scan_idx - NUM_LEAVES;
            end
            if (!grant_vld && req[scan_idx]) begin
                grant_vld = 1'b1;
                grant     = scan_idx[ID_W-1:0];
            end
        end
    end

    // Pointer advances past the granted lane only when the grant is actually taken.
    always_comb begin
        rr_d    = rr_q;
        next_rr = int'(grant) + 1;
        if (next_rr >= NUM_LEAVES) begin
            next_rr = 0;
        end
        if (out_load && grant_vld) begin
            rr_d = next_rr[ID_W-1:0];
        end
    end

    // Per-lane 2-entry FIFO: slot0 is the head, a pop shifts slot1 forward.
    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        ready_d = '0;
        pop     = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            pop[i] = out_load && grant_vld && (int'(grant) == i);
            case ({push[i], pop[i]})
                2'b10: begin
                    if (cnt_q[i] == 2'd0) begin
                        slot0_d[i] = bus.up_rx_data[i*64 +: 64];
                    end else begin
                        slot1_d[i] = bus.up_rx_data[i*64 +: 64];
                    end
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
                2'b01: begin
                    slot0_d[i] = slot1_q[i];
                    cnt_d[i]   = cnt_q[i] - 2'd1;
                end
                2'b11: begin
                    // A full lane has ready low, so push+pop only happens at count 1.
                    if (cnt_q[i] == 2'd1) begin
                        slot0_d[i] = bus.up_rx_data[i*64 +: 64];
                    end else begin
                        slot0_d[i] = slot1_q[i];
                        slot1_d[i] = bus.up_rx_data[i*64 +: 64];
                    end
                end
                default: begin
                end
            endcase
            ready_d[i] = (cnt_d[i] != 2'd2);
        end
    end

    // Output register loads the granted lane's head, or empties when drained with no grant.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (out_load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = slot0_q[grant];
                out_src_d  = grant;
            end
        end
    end

    // Control and output state; reset drops all buffered words and blocks the leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            ready_q     <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // FIFO payload storage; validity is carried entirely by the counts.
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign bus.up_rx_ready = ready_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_src_id  = out_src_q;
    assign bus.out_valid   = out_valid_q;

`ifdef UPLINK_BARRIER_EN
    logic [NUM_LEAVES-1:0] done_seen_q, done_seen_d;
    logic [NUM_LEAVES-1:0] seen_next;
    logic                  all_done_q, all_done_d;

    // Completion is counted when a DONE word leaves on the output, not on FIFO entry.
    always_comb begin
        done_seen_d = done_seen_q;
        seen_next   = done_seen_q;
        all_done_d  = 1'b0;
        if (out_valid_q && bus.out_ready && (out_data_q[63:56] == DONE_OPCODE)) begin
            seen_next[out_src_q] = 1'b1;
            if (&seen_next) begin
                all_done_d  = 1'b1;
                done_seen_d = '0;
            end else begin
                done_seen_d = seen_next;
            end
        end
    end

    // Barrier state and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_seen_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            done_seen_q <= done_seen_d;
            all_done_q  <= all_done_d;
        end
    end

    assign bus.all_done = all_done_q;
`else
    logic unused_done_opcode;
    assign unused_done_opcode = ^DONE_OPCODE;
    assign bus.all_done       = 1'b0;
`endif
endmodule

// File: tb/tb_root_uplink_collector.sv
// Testbench for root_uplink_collector: randomized leaf traffic plus directed
// scenarios, checked by a scoreboard of per-leaf expected-word queues.
`timescale 1ns/1ps
module tb_root_uplink_collector;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    root_uplink_collector_if #(.NUM_LEAVES(N), .ID_W(IDW)) bus ();

    root_uplink_collector #(
        .NUM_LEAVES (N),
        .ID_W       (IDW),
        .DONE_OPCODE(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] src_q [N][$];   // words each leaf still has to send
    logic [63:0] exp_q [N][$];   // words accepted from each leaf, not yet seen on output
    int          src_log [$];    // source tag of every output transfer

    int valid_pct = 100;
    int rdy_mode  = 0;           // 0: hold low, 1: high, 2: toggle, 3: random
    bit drv_kill  = 1'b0;

    int out_count   = 0;
    int acc_count   = 0;
    int pulse_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit idle();
        bit r;
        r = (bus.out_valid == 1'b0) && (bus.up_rx_valid == '0);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !idle()) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(idle()), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drv_kill = 1'b1;
        rdy_mode = 0;
        reset    = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        drv_kill = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaf and consumer driver: holds each word until accepted, then offers the next.
    initial begin
        bit took [N];
        bus.up_rx_valid = '0;
        bus.up_rx_data  = '0;
        bus.out_ready   = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                took[i] = !reset && bus.up_rx_valid[i] && bus.up_rx_ready[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (drv_kill || took[i]) bus.up_rx_valid[i] = 1'b0;
                if (!drv_kill && !bus.up_rx_valid[i] && src_q[i].size() > 0 &&
                    $urandom_range(0, 99) < valid_pct) begin
                    bus.up_rx_data[i*64 +: 64] = src_q[i].pop_front();
                    bus.up_rx_valid[i]         = 1'b1;
                end
            end
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: records accepted words, matches output transfers, models the barrier.
    initial begin
        bit seen [N];
        int nseen;
        bit pend;
        nseen = 0;
        pend  = 1'b0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < N; i++) begin
                    exp_q[i].delete();
                    seen[i] = 1'b0;
                end
                nseen = 0;
                pend  = 1'b0;
            end else begin
`ifdef UPLINK_BARRIER_EN
                check("all_done_pulse", 64'(bus.all_done), 64'(pend));
`else
                check("all_done_tied_low", 64'(bus.all_done), 64'd0);
`endif
                if (bus.all_done) pulse_count++;
                pend = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (bus.up_rx_valid[i] && bus.up_rx_ready[i]) begin
                        exp_q[i].push_back(bus.up_rx_data[i*64 +: 64]);
                        acc_count++;
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    int s;
                    s = int'(bus.out_src_id);
                    out_count++;
                    src_log.push_back(s);
                    if (exp_q[s].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: src=%0d data=%0h while nothing was expected",
                                 s, bus.out_data);
                    end else begin
                        check("scoreboard_data", bus.out_data, exp_q[s].pop_front());
                    end
`ifdef UPLINK_BARRIER_EN
                    if (bus.out_data[63:56] == 8'hFF && !seen[s]) begin
                        seen[s] = 1'b1;
                        nseen++;
                        if (nseen == N) begin
                            pend  = 1'b1;
                            nseen = 0;
                            for (int i = 0; i < N; i++) seen[i] = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed and randomized scenarios.
    initial begin
        int n;
        int base_acc;
        int base_out;
        int base_log;
        int base_p;
        logic [63:0] w;
        logic [63:0] first0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",   64'(bus.out_valid),   64'd0);
        check("rst_out_data",    bus.out_data,         64'd0);
        check("rst_out_src_id",  64'(bus.out_src_id),  64'd0);
        check("rst_up_rx_ready", 64'(bus.up_rx_ready), 64'h0);
        check("rst_all_done",    64'(bus.all_done),    64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'(bus.up_rx_ready), 64'hF);

        // Single word from leaf 2, minimum latency.
        rdy_mode  = 1;
        valid_pct = 100;
        src_q[2].push_back(64'h0000_0001_0002_0003);
        n = 0;
        while (!(bus.up_rx_valid[2] && bus.up_rx_ready[2]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("single_handshake", 64'(bus.up_rx_valid[2] && bus.up_rx_ready[2]), 64'd1);
        @(negedge clk);
        check("single_not_early", 64'(bus.out_valid),   64'd0);
        check("single_ready_a",   64'(bus.up_rx_ready), 64'hF);
        @(negedge clk);
        check("single_out_valid", 64'(bus.out_valid),   64'd1);
        check("single_src",       64'(bus.out_src_id),  64'd2);
        check("single_data",      bus.out_data,         64'h0000_0001_0002_0003);
        check("single_ready_b",   64'(bus.up_rx_ready), 64'hF);
        wait_drain("single_drained", 50);

        // Round-robin with every leaf continuously valid.
        do_reset();
        rdy_mode  = 1;
        valid_pct = 100;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) src_q[i].push_back({8'(8'h20 + i), 24'h0, 32'(k)});
        end
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 12; k++) begin
            check("rr_no_bubble", 64'(bus.out_valid),  64'd1);
            check("rr_src",       64'(bus.out_src_id), 64'(k % N));
            @(negedge clk);
        end
        wait_drain("rr_drained", 200);

        // Back-pressure: out_ready low, all leaves valid.
        do_reset();
        rdy_mode  = 0;
        valid_pct = 100;
        base_acc  = acc_count;
        base_out  = out_count;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) src_q[i].push_back({8'(8'h30 + i), 24'h0, 32'(k)});
        end
        first0 = {8'h30, 24'h0, 32'd0};
        repeat (8) @(negedge clk);
        check("bp_ready_low",  64'(bus.up_rx_ready), 64'h0);
        check("bp_out_valid",  64'(bus.out_valid),   64'd1);
        check("bp_out_src",    64'(bus.out_src_id),  64'd0);
        check("bp_out_data",   bus.out_data,         first0);
        check("bp_accepted",   64'(acc_count - base_acc), 64'd9);
        rdy_mode = 1;
        wait_drain("bp_drained", 200);
        check("bp_out_count",  64'(out_count - base_out), 64'd12);

        // Per-leaf ordering with out_ready toggling.
        do_reset();
        rdy_mode  = 2;
        valid_pct = 100;
        base_out  = out_count;
        base_log  = src_log.size();
        src_q[1].push_back(64'd10);
        src_q[1].push_back(64'd11);
        src_q[1].push_back(64'd12);
        wait_drain("order_drained", 100);
        check("order_count", 64'(out_count - base_out), 64'd3);
        if (src_log.size() >= base_log + 3) begin
            for (int j = 0; j < 3; j++) check("order_src", 64'(src_log[base_log + j]), 64'd1);
        end

        // Reset with five words buffered.
        do_reset();
        rdy_mode  = 0;
        valid_pct = 100;
        base_acc  = acc_count;
        src_q[0].push_back(64'hA0);
        src_q[0].push_back(64'hA1);
        src_q[1].push_back(64'hB0);
        src_q[1].push_back(64'hB1);
        src_q[2].push_back(64'hC0);
        repeat (6) @(negedge clk);
        check("midrst_holding",  64'(bus.out_valid), 64'd1);
        check("midrst_accepted", 64'(acc_count - base_acc), 64'd5);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        drv_kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        drv_kill = 1'b0;
        rdy_mode = 1;
        base_out = out_count;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", 64'(bus.up_rx_ready), 64'hF);
        repeat (10) @(negedge clk);
        check("midrst_no_stale",   64'(out_count - base_out), 64'd0);
        check("midrst_still_idle", 64'(bus.out_valid), 64'd0);

        // Randomized traffic with random gaps and back-pressure.
        do_reset();
        rdy_mode  = 3;
        valid_pct = 60;
        base_out  = out_count;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 40; k++) begin
                w = {$urandom, $urandom};
                if (w[63:56] == 8'hFF) w[63:56] = 8'h00;
                src_q[i].push_back(w);
            end
        end
        wait_drain("rand_drained", 3000);
        check("rand_count", 64'(out_count - base_out), 64'd160);

`ifdef UPLINK_BARRIER_EN
        // Barrier: three leaves report, then the fourth completes the round.
        do_reset();
        rdy_mode  = 1;
        valid_pct = 100;
        base_p    = pulse_count;
        src_q[3].push_back({8'hFF, 56'd3});
        wait_drain("bar_d3", 50);
        src_q[0].push_back({8'hFF, 56'd0});
        wait_drain("bar_d0", 50);
        src_q[2].push_back({8'hFF, 56'd2});
        wait_drain("bar_d2", 50);
        repeat (2) @(negedge clk);
        check("bar_no_pulse", 64'(pulse_count - base_p), 64'd0);
        src_q[1].push_back({8'hFF, 56'd1});
        wait_drain("bar_d1", 50);
        repeat (2) @(negedge clk);
        check("bar_one_pulse", 64'(pulse_count - base_p), 64'd1);
        src_q[0].push_back({8'hFF, 56'h10});
        src_q[0].push_back({8'hFF, 56'h11});
        src_q[2].push_back({8'hFF, 56'h12});
        src_q[3].push_back({8'hFF, 56'h13});
        wait_drain("bar_r2a", 50);
        repeat (2) @(negedge clk);
        check("bar_round2_wait", 64'(pulse_count - base_p), 64'd1);
        src_q[1].push_back({8'hFF, 56'h14});
        wait_drain("bar_r2b", 50);
        repeat (2) @(negedge clk);
        check("bar_round2_pulse", 64'(pulse_count - base_p), 64'd2);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
